// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register and its frame counter.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : shift_pkg

// File: rtl/universal_shift_reg_if.sv
// Control/data bundle of the universal shift register; the rot line exists only
// when SHIFT_ROTATE_EN is defined.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8
);
  import shift_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);

  logic             en;
  mode_e            mode;
  logic             si;
  logic [WIDTH-1:0] pin;
`ifdef SHIFT_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic             so_r;
  logic             so_l;
  logic [CNT_W-1:0] bit_cnt;
  logic             frame_done;

  modport master (
    output en, mode, si, pin,
`ifdef SHIFT_ROTATE_EN
    output rot,
`endif
    input  q, so_r, so_l, bit_cnt, frame_done
  );

  modport slave (
    input  en, mode, si, pin,
`ifdef SHIFT_ROTATE_EN
    input  rot,
`endif
    output q, so_r, so_l, bit_cnt, frame_done
  );

endinterface : universal_shift_reg_if

// File: rtl/shift_frame_counter.sv
// Counts shifts modulo WIDTH and pulses frame_done for one cycle after the
// WIDTH-th shift of a frame; clear restarts the frame.
module shift_frame_counter
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             shift,
  input  logic             clear,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no path
    // leaves it unassigned and no latch can be inferred.
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      if (clear) begin
        cnt_d = '0;
      end else if (shift) begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next-state value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign bit_cnt    = cnt_q;
  assign frame_done = done_q;

endmodule : shift_frame_counter

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register (hold / shift right / shift left / load)
// with frame counting. Define SHIFT_ROTATE_EN to add the rot (rotate) input.
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  universal_shift_reg_if.slave bus
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             feed_r, feed_l;
  logic             shift, clear;

  // With rotation the bit leaving the register re-enters at the other end.
`ifdef SHIFT_ROTATE_EN
  assign feed_r = bus.rot ? q_q[0]       : bus.si;
  assign feed_l = bus.rot ? q_q[WIDTH-1] : bus.si;
`else
  assign feed_r = bus.si;
  assign feed_l = bus.si;
`endif

  always_comb begin
    q_d   = q_q;
    shift = 1'b0;
    clear = 1'b0;
    case (bus.mode)
      MODE_SHR: begin
        shift = 1'b1;
        if (bus.en) q_d = {feed_r, q_q[WIDTH-1:1]};
      end
      MODE_SHL: begin
        shift = 1'b1;
        if (bus.en) q_d = {q_q[WIDTH-2:0], feed_l};
      end
      MODE_LOAD: begin
        clear = 1'b1;
        if (bus.en) q_d = bus.pin;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  shift_frame_counter #(.WIDTH(WIDTH)) u_frame_counter (
    .clk        (clk),
    .rst        (rst),
    .en         (bus.en),
    .shift      (shift),
    .clear      (clear),
    .bit_cnt    (bus.bit_cnt),
    .frame_done (bus.frame_done)
  );

  assign bus.q    = q_q;
  assign bus.so_r = q_q[0];
  assign bus.so_l = q_q[WIDTH-1];

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// Directed and randomized bench for universal_shift_reg against an arithmetic
// reference model of the register contents and frame position.
module tb_universal_shift_reg;
  import shift_pkg::*;

  localparam int W = 8;
`ifdef SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  universal_shift_reg_if #(.WIDTH(W)) bus ();
  universal_shift_reg #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: register value, shifts taken in the current frame, pulse.
  logic [W-1:0] m_q;
  int           m_shifts;
  bit           m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".q"},          32'(bus.q),       32'(m_q));
    check({tag, ".so_r"},       32'(bus.so_r),    32'(m_q[0]));
    check({tag, ".so_l"},       32'(bus.so_l),    32'(m_q[W-1]));
    check({tag, ".bit_cnt"},    32'(bus.bit_cnt), 32'(m_shifts));
    check({tag, ".frame_done"}, 32'(bus.frame_done), 32'(m_done));
  endtask

  task automatic model_count_shift();
    m_shifts = m_shifts + 1;
    m_done   = (m_shifts == W);
    if (m_done) m_shifts = 0;
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 ns later.
  task automatic cyc(input string tag, input logic e, input mode_e m, input logic s,
                     input logic [W-1:0] p, input logic r);
    logic fb;
    bus.en   = e;
    bus.mode = m;
    bus.si   = s;
    bus.pin  = p;
`ifdef SHIFT_ROTATE_EN
    bus.rot  = r;
`endif
    @(posedge clk);
    m_done = 1'b0;
    if (e) begin
      case (m)
        MODE_SHR: begin
          fb  = (ROT_EN && r) ? m_q[0] : s;
          m_q = (m_q >> 1) | (W'(fb) << (W - 1));
          model_count_shift();
        end
        MODE_SHL: begin
          fb  = (ROT_EN && r) ? m_q[W-1] : s;
          m_q = (m_q << 1) | W'(fb);
          model_count_shift();
        end
        MODE_LOAD: begin
          m_q      = p;
          m_shifts = 0;
        end
        default: ;
      endcase
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [W-1:0] siso_bits;
    logic [W-1:0] held_q;
    logic [W-1:0] exp_rot;
    int           done_seen;

    bus.en   = 1'b0;
    bus.mode = MODE_HOLD;
    bus.si   = 1'b0;
    bus.pin  = '0;
`ifdef SHIFT_ROTATE_EN
    bus.rot  = 1'b0;
`endif
    m_q      = '0;
    m_shifts = 0;
    m_done   = 1'b0;

    #12;
    check("reset.q",          32'(bus.q), 0);
    check("reset.bit_cnt",    32'(bus.bit_cnt), 0);
    check("reset.frame_done", 32'(bus.frame_done), 0);
    check("reset.so_r",       32'(bus.so_r), 0);
    check("reset.so_l",       32'(bus.so_l), 0);
    rst = 1'b1;

    // SISO / SIPO: bit i of siso_bits is the i-th serial bit sent.
    siso_bits = 8'b1110_0111;
    for (int i = 0; i < W; i++) cyc("siso", 1'b1, MODE_SHR, siso_bits[i], '0, 1'b0);
    check("siso.q_final",     32'(bus.q), 32'h0000_00E7);
    check("siso.bit_cnt",     32'(bus.bit_cnt), 0);
    check("siso.frame_done",  32'(bus.frame_done), 1);
    cyc("siso.hold", 1'b1, MODE_HOLD, 1'b0, '0, 1'b0);
    check("siso.pulse_end",   32'(bus.frame_done), 0);
    for (int i = 0; i < W; i++) begin
      check("siso.so_r_order", 32'(bus.so_r), 32'(siso_bits[i]));
      cyc("siso.drain", 1'b1, MODE_SHR, 1'b0, '0, 1'b0);
    end

    // PISO: the two set bits of 8'h81 leave via so_l now and after 7 shifts.
    cyc("piso.load", 1'b1, MODE_LOAD, 1'b0, 8'h81, 1'b0);
    check("piso.so_l_first", 32'(bus.so_l), 1);
    for (int k = 1; k <= W; k++) begin
      cyc("piso.shl", 1'b1, MODE_SHL, 1'b0, '0, 1'b0);
      check("piso.so_l", 32'(bus.so_l), (k == 7) ? 1 : 0);
    end
    check("piso.q_empty",    32'(bus.q), 0);
    check("piso.frame_done", 32'(bus.frame_done), 1);

    // Enable and hold mid-frame at bit_cnt = 3.
    cyc("hold.load", 1'b1, MODE_LOAD, 1'b0, 8'h3C, 1'b0);
    for (int k = 0; k < 3; k++) cyc("hold.pre", 1'b1, MODE_SHR, 1'($urandom), '0, 1'b0);
    check("hold.bit_cnt3", 32'(bus.bit_cnt), 3);
    held_q = m_q;
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 1) cyc("hold.en0", 1'b0, MODE_SHR, 1'b1, 8'hFF, 1'b1);
      else            cyc("hold.mode", 1'b1, MODE_HOLD, 1'b1, 8'hFF, 1'b1);
      check("hold.q_frozen",   32'(bus.q), 32'(held_q));
      check("hold.cnt_frozen", 32'(bus.bit_cnt), 3);
      check("hold.no_done",    32'(bus.frame_done), 0);
    end
    for (int k = 0; k < 5; k++) begin
      cyc("hold.post", 1'b1, MODE_SHL, 1'($urandom), '0, 1'b0);
      check("hold.done_at_5", 32'(bus.frame_done), (k == 4) ? 1 : 0);
    end

    // Load mid-frame at bit_cnt = 6 restarts the frame.
    for (int k = 0; k < 6; k++) cyc("midload.pre", 1'b1, MODE_SHR, 1'($urandom), '0, 1'b0);
    check("midload.bit_cnt6", 32'(bus.bit_cnt), 6);
    cyc("midload.load", 1'b1, MODE_LOAD, 1'b0, 8'h5A, 1'b0);
    check("midload.cnt_clr", 32'(bus.bit_cnt), 0);
    check("midload.no_done", 32'(bus.frame_done), 0);
    for (int k = 0; k < W; k++) begin
      cyc("midload.frame", 1'b1, (k % 3 == 0) ? MODE_SHR : MODE_SHL, 1'($urandom), '0, 1'b0);
      check("midload.done_at_8", 32'(bus.frame_done), (k == W - 1) ? 1 : 0);
    end

    // Randomized operation against the model.
    repeat (400) begin
      cyc("rand", ($urandom_range(0, 7) != 0), mode_e'($urandom_range(0, 3)),
          1'($urandom), W'($urandom), 1'($urandom));
    end

`ifdef SHIFT_ROTATE_EN
    // Rotate right: a single set bit walks all the way round.
    cyc("rot.load", 1'b1, MODE_LOAD, 1'b0, 8'h01, 1'b1);
    done_seen = 0;
    for (int k = 1; k <= W; k++) begin
      cyc("rot.shr", 1'b1, MODE_SHR, 1'b0, '0, 1'b1);
      exp_rot = 8'h80 >> (k - 1);
      check("rot.q_walk", 32'(bus.q), 32'(exp_rot));
      done_seen += int'(bus.frame_done);
    end
    cyc("rot.hold", 1'b1, MODE_HOLD, 1'b0, '0, 1'b1);
    done_seen += int'(bus.frame_done);
    check("rot.done_once", 32'(done_seen), 1);
`endif

    // Asynchronous reset between clock edges, mid-frame.
    cyc("arst.load", 1'b1, MODE_LOAD, 1'b0, 8'hA5, 1'b0);
    for (int k = 0; k < 3; k++) cyc("arst.shr", 1'b1, MODE_SHR, 1'b0, '0, 1'b0);
    check("arst.pre_q",   32'(bus.q), 32'h0000_0014);
    check("arst.pre_cnt", 32'(bus.bit_cnt), 3);
    #2;
    rst = 1'b0;
    #1;
    check("arst.q",          32'(bus.q), 0);
    check("arst.bit_cnt",    32'(bus.bit_cnt), 0);
    check("arst.frame_done", 32'(bus.frame_done), 0);
    check("arst.so_r",       32'(bus.so_r), 0);
    check("arst.so_l",       32'(bus.so_l), 0);
    m_q      = '0;
    m_shifts = 0;
    m_done   = 1'b0;
    rst = 1'b1;
    cyc("arst.resume", 1'b1, MODE_SHR, 1'b1, '0, 1'b0);
    check("arst.resume_cnt", 32'(bus.bit_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_universal_shift_reg
